// File: rtl/tick_gen_prog.sv
`default_nettype none
// ============================================================================
//  Module   : tick_gen_prog
//  Purpose  : Programmable clock-enable tick source. The period register can
//             be reloaded at run time. Periodic and one-shot modes,
//             start/retrigger, and a count-enable pause are supported. A
//             single counter is used per instance.
//
//  Parameters
//    WIDTH       period / counter width in bits
//    RST_PERIOD  period register value after reset (must fit in WIDTH bits)
//    AUTO_START  1: reset into RUN, 0: reset into IDLE
//
//  Ports
//    clk         rising-edge clock
//    rst         synchronous active-high reset
//    en          count enable; when low the counter holds and tick is 0
//    mode        0 = periodic, 1 = one-shot (sampled on the tick edge)
//    start       single-cycle start / retrigger request
//    load        single-cycle write of period_in into the period register
//    period_in   new period in clk cycles
//    tick        one-cycle pulse at the terminal count
//    busy        high while in RUN
//    period_out  current period register
//    tick_cnt    (only with TICK_GEN_TICK_CNT_EN defined) saturating count of
//                emitted ticks; cleared by rst or load
//
//  Build option
//    `define TICK_GEN_TICK_CNT_EN to add the tick_cnt output and its register.
//
//  Revision : 1.0  initial release
// ============================================================================
module tick_gen_prog #(
    parameter int WIDTH      = 19,
    parameter int RST_PERIOD = 500000,
    parameter bit AUTO_START = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             start,
    input  logic             load,
    input  logic [WIDTH-1:0] period_in,
    output logic             tick,
    output logic             busy,
    output logic [WIDTH-1:0] period_out
`ifdef TICK_GEN_TICK_CNT_EN
    ,
    output logic [15:0]      tick_cnt
`endif
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] c_rst_period = WIDTH'(RST_PERIOD);
    localparam logic [WIDTH-1:0] c_one        = WIDTH'(1);
    localparam state_t           c_rst_state  = AUTO_START ? S_RUN : S_IDLE;

    state_t           r_state;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_count;

    logic [WIDTH-1:0] w_term;
    logic             w_tick;

    // Periods 0 and 1 both collapse to a terminal count of 0, so the block
    // ticks on every enabled cycle instead of never reaching the terminal.
    assign w_term = (r_period <= c_one) ? '0 : (r_period - c_one);
    assign w_tick = (r_state == S_RUN) && en && (r_count == w_term);

    // Priority chain: reset, load, start, tick, count. Every branch that
    // touches the period or the run state clears the counter, which keeps
    // the counter at 0 in IDLE and avoids wrapping past a shrunken period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_rst_state;
            r_count  <= '0;
            r_period <= c_rst_period;
        end else if (load) begin
            // A simultaneous start is ignored on this edge.
            r_period <= period_in;
            r_count  <= '0;
        end else if (start) begin
            r_state  <= S_RUN;
            r_count  <= '0;
        end else if (w_tick) begin
            r_count  <= '0;
            if (mode) begin
                r_state <= S_IDLE;
            end
        end else if ((r_state == S_RUN) && en) begin
            r_count  <= r_count + c_one;
        end
    end

    assign tick       = w_tick;
    assign busy       = (r_state == S_RUN);
    assign period_out = r_period;

`ifdef TICK_GEN_TICK_CNT_EN
    logic [15:0] r_tick_cnt;

    // Counts edges on which a tick is emitted, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_tick_cnt <= '0;
        end else if (w_tick && (r_tick_cnt != 16'hFFFF)) begin
            r_tick_cnt <= r_tick_cnt + 16'd1;
        end
    end

    assign tick_cnt = r_tick_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tick_gen_prog.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tick_gen_prog
//  Purpose  : Self-checking bench for tick_gen_prog (WIDTH=8, RST_PERIOD=5,
//             AUTO_START=1). The stimulus side predicts each cycle's outputs
//             with a countdown model and queues them; a monitor pops and
//             compares on the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tick_gen_prog;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         mode;
    logic         start;
    logic         load;
    logic [W-1:0] period_in;
    logic         tick;
    logic         busy;
    logic [W-1:0] period_out;
`ifdef TICK_GEN_TICK_CNT_EN
    logic [15:0]  tick_cnt;
`endif

    always #5 clk = ~clk;

    tick_gen_prog #(
        .WIDTH      (W),
        .RST_PERIOD (5),
        .AUTO_START (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .start      (start),
        .load       (load),
        .period_in  (period_in),
        .tick       (tick),
        .busy       (busy),
        .period_out (period_out)
`ifdef TICK_GEN_TICK_CNT_EN
        ,
        .tick_cnt   (tick_cnt)
`endif
    );

    typedef struct {
        logic         tick;
        logic         busy;
        logic [W-1:0] per;
        int           cnt;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Behavioural model: "rem" is the number of enabled cycles still to go
    // before the next tick, counted down; tick fires on the last one.
    bit   m_run;
    int   m_per;
    int   m_rem;
    int   m_cnt;

    function automatic int eff(input int p);
        return (p <= 1) ? 1 : p;
    endfunction

    task automatic step(input bit r, input bit e, input bit m, input bit s,
                        input bit l, input int pin);
        exp_t x;
        rst = r; en = e; mode = m; start = s; load = l; period_in = W'(pin);
        x.tick = m_run && e && (m_rem == 1);
        x.busy = m_run;
        x.per  = W'(m_per);
        x.cnt  = m_cnt;
        x.cyc  = cyc;
        q.push_back(x);
        if (!r && !l && x.tick && m_cnt != 65535) m_cnt++;
        if (r) begin
            m_run = 1'b1; m_per = 5; m_rem = 5; m_cnt = 0;
        end else if (l) begin
            m_per = pin % 256; m_rem = eff(m_per); m_cnt = 0;
        end else if (s) begin
            m_run = 1'b1; m_rem = eff(m_per);
        end else if (x.tick) begin
            m_rem = eff(m_per);
            if (m) m_run = 1'b0;
        end else if (m_run && e) begin
            m_rem--;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Monitor: outputs are valid every cycle, so one entry is consumed per
    // falling edge once the model has started predicting.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            bit   bad;
            x = q.pop_front();
            n_vec++;
            bad = (tick !== x.tick) || (busy !== x.busy) || (period_out !== x.per);
`ifdef TICK_GEN_TICK_CNT_EN
            bad = bad || (int'(tick_cnt) !== x.cnt);
`endif
            if (bad) begin
                n_err++;
                $display("FAIL outputs cyc=%0d: got tick=%b busy=%b period=%0d, want tick=%b busy=%b period=%0d cnt=%0d",
                         x.cyc, tick, busy, period_out, x.tick, x.busy, x.per, x.cnt);
            end
        end
    end

    initial begin
        bit rm;
        rst = 1'b1; en = 1'b1; mode = 1'b0; start = 1'b0; load = 1'b0; period_in = '0;
        @(posedge clk);
        #1;
        m_run = 1'b1; m_per = 5; m_rem = 5; m_cnt = 0;

        // Reset held one more cycle, then free-run with period 5.
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0, 0);
        // Load 3 while running.
        step(0, 1, 0, 0, 1, 3);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 0);
        // Retrigger with period 5 and a two-cycle pause.
        step(0, 1, 0, 0, 1, 5);
        step(0, 1, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) step(0, 1, 0, 0, 0, 0);
        // Periods 0 and 1.
        step(0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);
        // One-shot with period 4, then load+start together while idle.
        step(0, 1, 1, 0, 1, 4);
        for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 1, 6);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 1, 0, 0, 0);

        // Randomised phase.
        rm = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3) rm = ~rm;
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 99) < 85,
                 rm,
                 $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 4,
                 ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 12)));
        end

`ifdef TICK_GEN_TICK_CNT_EN
        // Saturation of the tick counter, then clear by load.
        step(0, 1, 0, 0, 1, 1);
        step(0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 66000; i++) step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 7);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
`endif

        @(negedge clk);
        #1;
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d entries left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tick_gen_prog.md
# tick_gen_prog

Programmable tick generator: a clock-enable pulse source whose period is loadable at run time, with periodic and one-shot modes, start/retrigger and a count-enable pause. It replaces the fixed 5 ms tick generators feeding the display-refresh, debounce and UART-timeout logic, and it uses a single counter per instance. With `AUTO_START=1` and `RST_PERIOD=500000` it matches the fixed 5 ms generator cycle for cycle.

## Interface
- `WIDTH`, 19: period and counter width in bits.
- `RST_PERIOD`, 500000: period register value after reset, in clk cycles. Must fit in `WIDTH` bits.
- `AUTO_START`, 1: reset state is RUN when 1, IDLE when 0.

Ports:
- `clk`  in  1  on-board clock. All state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  count enable. When 0, the counter holds and `tick` is forced to 0.
- `mode`  in  1  0 = periodic, 1 = one-shot. Sampled at the tick edge.
- `start`  in  1  single-cycle request to start or retrigger.
- `load`  in  1  single-cycle request to write `period_in` into the period register.
- `period_in`  in  WIDTH  new period, in cycles.
- `tick`  out  1  one-cycle pulse at the terminal count.
- `busy`  out  1  high while the state is RUN.
- `period_out`  out  WIDTH  current period register.

## Operation
- Registers:
  - period `P`, reset value `RST_PERIOD`.
  - counter `count`, reset value 0.
  - state IDLE or RUN.
- Terminal value: `T = (P <= 1) ? 0 : P-1`. Periods 0 and 1 both produce a tick on every enabled cycle.
- `tick = (state==RUN) && en && (count==T)`. This is combinational from the registers and `en`.
- Per-edge priority, highest first:
  1. `rst`: state ← (`AUTO_START` ? RUN : IDLE), `count` ← 0, `P` ← `RST_PERIOD`.
  2. `load`: `P` ← `period_in`, `count` ← 0. State is unchanged.
  3. `start`: state ← RUN, `count` ← 0. Applies in both IDLE and RUN; in RUN this is a retrigger.
  4. `tick`: `count` ← 0. If `mode`=1, state ← IDLE; otherwise the state stays RUN.
  5. RUN && `en`: `count` ← `count`+1.
  6. Otherwise, hold.
- `start` and `load` asserted in the same cycle: `load` wins. That edge writes `P` and clears `count`; `start` is ignored, so an IDLE block stays IDLE.
- In IDLE, `count` stays at 0 and `tick` stays at 0.
- If `P` is reloaded below the current `count`, the counter is cleared anyway, so there is no wrap-around past 2^WIDTH.
- `period_out` = `P`. `busy` = (state==RUN).

## Timing
- Reset values:
  - `tick`: 0, since `count`=0 and T>0 when `RST_PERIOD`>1.
  - `busy`: `AUTO_START`.
  - `period_out`: `RST_PERIOD`.
- With `en` held at 1 and a start (or reset release) at edge k, the first `tick` is high during the cycle after edge k+T. This is P cycles after the start.
- Periodic mode: ticks repeat every P enabled cycles, with exactly one high cycle per period.
- `en` low for n cycles stretches the period by exactly n cycles. A tick suppressed by `en`=0 is delayed, not lost.
- A `load` takes effect from the next edge; the next tick follows P_new enabled cycles later.
- One-shot mode: `busy` drops on the edge that ends the tick cycle.

## Configuration
- `TICK_GEN_TICK_CNT_EN`
  - Defined: adds output `tick_cnt` [15:0], a saturating count of emitted ticks.
    - Cleared by `rst` or `load`.
    - Increments on each edge where `tick`=1.
    - Holds at 16'hFFFF once reached.
  - Undefined: the port and its register are absent, and all other behaviour is identical.

## Test plan
- Reset/auto-run (WIDTH=8, RST_PERIOD=5, AUTO_START=1, `en`=1) → `tick` is high in cycles 5, 10, 15 after reset release, and low in all other cycles.
- Load while running: `load`=1 with `period_in`=3 at cycle 7 → next ticks in cycles 10, 13, 16; `period_out` reads 3 from cycle 8.
- One-shot (AUTO_START=0, P=4, `mode`=1), `start` at cycle 2 → single tick in cycle 6, `busy` high during cycles 3–6, then IDLE with no further ticks.
- Retrigger and pause (P=5, periodic): `start` at cycle 3, then `en`=0 during cycles 5–6 → tick in cycle 10, then every 5 cycles.
- Edge periods and priority:
  - `period_in`=0 and `period_in`=1 → tick every enabled cycle.
  - `load`+`start` together while IDLE → stays IDLE, `count`=0, `P` updated.
- With `TICK_GEN_TICK_CNT_EN` defined, P=1 for 70000 cycles → `tick_cnt` saturates at 65535; a `load` clears it to 0.
